lms_adapt_ctrl: RTL and testbench

Sequencer for the tone/noise -> FIR -> LMS datapath. Generates the per-sample clock enable, debounces the board switches, and switches the LMS desired-signal source only at sample boundaries. Runs the adaptation life-cycle: clear weights, flush pipelines, adapt, then optionally freeze on convergence and re-adapt on divergence. Sits beside the datapath in the top level and replaces the free-running clock-enable block.

---
 rtl/filter_ctrl_pkg.sv | 33 +++
 rtl/sw_debounce.sv | 49 ++++
 rtl/lms_adapt_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lms_adapt_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the LMS adaptation sequencer.
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_ADAPT  = 3'd3,
        ST_FROZEN = 3'd4
    } state_e;

    localparam int SW_SEL    = 0;
    localparam int SW_FREEZE = 1;
    localparam int SW_CLR    = 2;
    localparam int SW_W      = 3;

    localparam int          CLK_DIV_DEF       = 450;
    localparam int          DB_SAMPLES_DEF    = 64;
    localparam int          FLUSH_SAMPLES_DEF = 64;
    localparam int          WIN_LOG2_DEF      = 8;
    localparam logic [15:0] CONV_THRESH_DEF   = 16'd2048;

    // |e| clamped so the most negative code maps to the largest positive one.
    function automatic logic [14:0] abs_sat(input logic [15:0] e);
        logic [15:0] mag;
        if (e == 16'h8000) begin
            return 15'h7fff;
        end
        mag = e[15] ? (~e + 16'd1) : e;
        return mag[14:0];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser plus stability filter; a change is accepted once it has
// persisted for DB_SAMPLES ticks, and any return to the old value restarts the count.
module sw_debounce #(
    parameter int W          = 3,
    parameter int DB_SAMPLES = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         tick_i,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o
);

    localparam int CW = $clog2(DB_SAMPLES + 1);

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [W-1:0]  stable_q;
    logic [CW-1:0] cnt_q [W];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            for (int i = 0; i < W; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (tick_i) begin
                    if (cnt_q[i] == CW'(DB_SAMPLES - 1)) begin
                        stable_q[i] <= sync2_q[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/lms_adapt_ctrl.sv
// Sample-rate sequencer for the LMS datapath: strobe generation, switch debounce,
// and the clear/flush/adapt/freeze life-cycle. All outputs come straight from flops.
module lms_adapt_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int          CLK_DIV       = CLK_DIV_DEF,
    parameter int          DB_SAMPLES    = DB_SAMPLES_DEF,
    parameter int          FLUSH_SAMPLES = FLUSH_SAMPLES_DEF,
    parameter int          WIN_LOG2      = WIN_LOG2_DEF,
    parameter logic [15:0] CONV_THRESH   = CONV_THRESH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sw_raw,
    input  logic [15:0] err,
    output logic        sample_en,
    output logic        sel_fir,
    output logic        adapt_en,
    output logic        weight_clr,
    output logic        converged,
    output logic [2:0]  state
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int FL_W  = $clog2(FLUSH_SAMPLES + 1);
    localparam int ACC_W = 15 + WIN_LOG2;

    logic [DIV_W-1:0]    div_q, div_d;
    logic                sample_en_q;
    logic [SW_W-1:0]     db_sw;
    logic [SW_W-1:0]     db_prev_q;
    state_e              state_q;
    logic [FL_W-1:0]     flush_cnt_q;
    logic [WIN_LOG2-1:0] win_q;
    logic [ACC_W-1:0]    acc_q;
    logic                sel_fir_q, adapt_en_q, weight_clr_q, converged_q;

    logic [14:0]         err_abs;
    logic [ACC_W-1:0]    acc_sum;
    logic [14:0]         mean;
    logic                win_done, mean_low, mean_high;
    logic                mode_chg, clr_req, freeze;
    logic                sw_unused;

    assign sw_unused = ^sw_raw[7:3];

    assign div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            sample_en_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            sample_en_q <= (div_d == DIV_W'(CLK_DIV - 1));
        end
    end

    sw_debounce #(
        .W          (SW_W),
        .DB_SAMPLES (DB_SAMPLES)
    ) u_db (
        .clk_i    (clk),
        .reset_i  (reset),
        .tick_i   (sample_en_q),
        .raw_i    (sw_raw[SW_W-1:0]),
        .stable_o (db_sw)
    );

    assign mode_chg = db_sw[SW_SEL] ^ db_prev_q[SW_SEL];
    assign clr_req  = db_sw[SW_CLR] & ~db_prev_q[SW_CLR];
    assign freeze   = db_sw[SW_FREEZE];

    // The window-completing sample is folded in before the mean is taken.
    assign err_abs   = abs_sat(err);
    assign acc_sum   = acc_q + ACC_W'(err_abs);
    assign mean      = acc_sum[ACC_W-1:WIN_LOG2];
    assign win_done  = (win_q == '1);
    assign mean_low  = ({2'b00, mean} <= {1'b0, CONV_THRESH});
    assign mean_high = ({2'b00, mean} > {CONV_THRESH, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            db_prev_q    <= '0;
            flush_cnt_q  <= '0;
            win_q        <= '0;
            acc_q        <= '0;
            sel_fir_q    <= 1'b0;
            adapt_en_q   <= 1'b0;
            weight_clr_q <= 1'b0;
            converged_q  <= 1'b0;
        end else if (sample_en_q) begin
            db_prev_q <= db_sw;
            if (state_q == ST_IDLE || mode_chg || clr_req) begin
                state_q      <= ST_CLEAR;
                sel_fir_q    <= db_sw[SW_SEL];
                weight_clr_q <= 1'b1;
                adapt_en_q   <= 1'b0;
                converged_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        state_q      <= ST_FLUSH;
                        weight_clr_q <= 1'b0;
                        flush_cnt_q  <= '0;
                    end
                    ST_FLUSH: begin
                        if (flush_cnt_q == FL_W'(FLUSH_SAMPLES - 1)) begin
                            state_q    <= ST_ADAPT;
                            adapt_en_q <= 1'b1;
                            acc_q      <= '0;
                            win_q      <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + FL_W'(1);
                        end
                    end
                    ST_ADAPT: begin
                        if (win_done) begin
                            acc_q <= '0;
                            win_q <= '0;
                            if (freeze && mean_low) begin
                                state_q     <= ST_FROZEN;
                                adapt_en_q  <= 1'b0;
                                converged_q <= 1'b1;
                            end
                        end else begin
                            acc_q <= acc_sum;
                            win_q <= win_q + WIN_LOG2'(1);
                        end
                    end
                    ST_FROZEN: begin
                        if (!freeze || (win_done && mean_high)) begin
                            state_q     <= ST_ADAPT;
                            adapt_en_q  <= 1'b1;
                            converged_q <= 1'b0;
                            acc_q       <= '0;
                            win_q       <= '0;
                        end else if (win_done) begin
                            acc_q <= '0;
                            win_q <= '0;
                        end else begin
                            acc_q <= acc_sum;
                            win_q <= win_q + WIN_LOG2'(1);
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        adapt_en_q   <= 1'b0;
                        weight_clr_q <= 1'b0;
                        converged_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_en  = sample_en_q;
    assign sel_fir    = sel_fir_q;
    assign adapt_en   = adapt_en_q;
    assign weight_clr = weight_clr_q;
    assign converged  = converged_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Directed bench for lms_adapt_ctrl with a 4-clk sample period and short debounce/flush/window.
module tb_lms_adapt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw_raw;
    logic [15:0] err;
    logic        sample_en, sel_fir, adapt_en, weight_clr, converged;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_FLUSH = 3'd2,
                           S_ADAPT = 3'd3, S_FROZEN = 3'd4;

    lms_adapt_ctrl #(
        .CLK_DIV       (4),
        .DB_SAMPLES    (2),
        .FLUSH_SAMPLES (4),
        .WIN_LOG2      (2),
        .CONV_THRESH   (16'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .err        (err),
        .sample_en  (sample_en),
        .sel_fir    (sel_fir),
        .adapt_en   (adapt_en),
        .weight_clr (weight_clr),
        .converged  (converged),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the point where sample_en is visible (just before its state-update edge).
    task automatic wait_strobe();
        int g = 0;
        while (sample_en !== 1'b1 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) chk("strobe_timeout", 32'(g), 32'(0));
    endtask

    task automatic tick();
        wait_strobe();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic measure_clr(input string tag);
        int n = 0;
        while (weight_clr === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk(tag, 32'(n), 32'(4));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
        chk({tag, "_outs"}, {26'd0, sample_en, sel_fir, adapt_en, weight_clr, converged, 1'b0}, 32'd0);
    endtask

    // Reset release through to ADAPT: strobe every 4 clks, 4-clk CLEAR, 4-sample FLUSH.
    task automatic startup(input string tag);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_no_early_strobe"}, 32'(sample_en), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_first_strobe"}, 32'(sample_en), 32'd1);
        chk({tag, "_idle_at_strobe"}, 32'(state), 32'(S_IDLE));
        @(posedge clk); #1;
        chk({tag, "_clear"}, 32'(state), 32'(S_CLEAR));
        chk({tag, "_sel0"}, 32'(sel_fir), 32'd0);
        chk({tag, "_no_adapt_in_clear"}, 32'(adapt_en), 32'd0);
        measure_clr({tag, "_clr_len"});
        chk({tag, "_flush"}, 32'(state), 32'(S_FLUSH));
        ticks(3);
        chk({tag, "_still_flush"}, 32'(state), 32'(S_FLUSH));
        chk({tag, "_adapt_off_flush"}, 32'(adapt_en), 32'd0);
        tick();
        chk({tag, "_adapt"}, 32'(state), 32'(S_ADAPT));
        chk({tag, "_adapt_en"}, 32'(adapt_en), 32'd1);
        chk({tag, "_sel_still0"}, 32'(sel_fir), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = 8'h00;
        err    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        #1;
        check_idle("release");

        // 1: startup sequence
        startup("s1");

        // 2: converge on |err|=50, then diverge on 300
        sw_raw[1] = 1'b1;
        err = -16'sd50;
        ticks(3);
        chk("s2_adapt_mid_window", 32'(state), 32'(S_ADAPT));
        tick();
        chk("s2_frozen", 32'(state), 32'(S_FROZEN));
        chk("s2_converged", 32'(converged), 32'd1);
        chk("s2_adapt_off", 32'(adapt_en), 32'd0);
        err = 16'd300;
        ticks(3);
        chk("s2_frozen_mid_window", 32'(state), 32'(S_FROZEN));
        tick();
        chk("s2_readapt", 32'(state), 32'(S_ADAPT));
        chk("s2_conv_drop", 32'(converged), 32'd0);
        chk("s2_adapt_on", 32'(adapt_en), 32'd1);

        // 3: saturation of -32768, then threshold boundaries
        err = 16'h8000;
        ticks(4);
        chk("s3_sat_stays_adapt", 32'(state), 32'(S_ADAPT));
        chk("s3_sat_adapt_en", 32'(adapt_en), 32'd1);
        err = -16'sd100;
        ticks(4);
        chk("s3_mean_eq_thresh_frozen", 32'(state), 32'(S_FROZEN));
        err = 16'd200;
        ticks(4);
        chk("s3_mean_eq_2thresh_frozen", 32'(state), 32'(S_FROZEN));
        chk("s3_conv_held", 32'(converged), 32'd1);
        sw_raw[1] = 1'b0;
        ticks(2);
        chk("s3_freeze_debouncing", 32'(state), 32'(S_FROZEN));
        tick();
        chk("s3_unfreeze_adapt", 32'(state), 32'(S_ADAPT));
        sw_raw[1] = 1'b1;
        err = -16'sd50;
        ticks(4);
        chk("s3_refrozen", 32'(state), 32'(S_FROZEN));

        // 5: sel and clear rise together while FROZEN -> one CLEAR
        sw_raw[0] = 1'b1;
        sw_raw[2] = 1'b1;
        ticks(2);
        chk("s5_frozen_debouncing", 32'(state), 32'(S_FROZEN));
        tick();
        chk("s5_clear", 32'(state), 32'(S_CLEAR));
        chk("s5_conv_drop", 32'(converged), 32'd0);
        chk("s5_sel1", 32'(sel_fir), 32'd1);
        measure_clr("s5_single_clear");
        chk("s5_flush", 32'(state), 32'(S_FLUSH));
        sw_raw[0] = 1'b0;
        sw_raw[2] = 1'b0;
        ticks(3);
        chk("s5_sel_fall_clear", 32'(state), 32'(S_CLEAR));
        chk("s5_sel0", 32'(sel_fir), 32'd0);
        measure_clr("s5_fall_clr_len");

        // 4: one-sample glitch ignored, held change accepted
        sw_raw[0] = 1'b1;
        tick();
        sw_raw[0] = 1'b0;
        tick();
        chk("s4_glitch_flush", 32'(state), 32'(S_FLUSH));
        ticks(2);
        chk("s4_glitch_no_event", 32'(state), 32'(S_ADAPT));
        sw_raw[0] = 1'b1;
        ticks(2);
        wait_strobe();
        chk("s4_pre_edge_state", 32'(state), 32'(S_ADAPT));
        chk("s4_pre_edge_sel", 32'(sel_fir), 32'd0);
        @(posedge clk); #1;
        chk("s4_clear", 32'(state), 32'(S_CLEAR));
        chk("s4_sel_rise", 32'(sel_fir), 32'd1);
        measure_clr("s4_clr_len");
        chk("s4_flush", 32'(state), 32'(S_FLUSH));

        // 6: async reset mid-FLUSH between strobes, then clean restart
        tick();
        @(posedge clk); #1;
        chk("s6_pre_reset_flush", 32'(state), 32'(S_FLUSH));
        sw_raw = 8'h00;
        err    = 16'h0000;
        reset  = 1'b1;
        #2;
        check_idle("s6_async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        startup("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
